io_link_peer: RTL and testbench

//  Device-side endpoint of the CPU I/O link. It feeds the CPU input buffer and drains the CPU output buffer.
//  TX path: queues device words and presents one on link_tx_data per CPU-side tick (a link_tx_clk toggle).
//  RX path: captures link_rx_data on each link_rx_clk toggle that has link_rx_valid high, and queues it for the device.

---
 rtl/io_link_peer.sv | 112 +++++++++++
 tb/tb_io_link_peer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/io_link_peer.sv
// io_link_peer: device-side endpoint of the CPU I/O link
// TX FIFO drained one word per link_tx_clk toggle; RX FIFO filled on valid link_rx_clk toggles.
module io_link_peer #(
   parameter int TX_WIDTH = 16,
   parameter int RX_WIDTH = 13,
   parameter int DEPTH    = 16,
   parameter int AW       = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [TX_WIDTH-1:0] dev_tx_data,
   input  logic                dev_tx_wr,
   output logic                dev_tx_full,
   input  logic                link_tx_clk,
   output logic [TX_WIDTH-1:0] link_tx_data,
   input  logic                link_rx_clk,
   input  logic [RX_WIDTH-1:0] link_rx_data,
   input  logic                link_rx_valid,
   output logic [RX_WIDTH-1:0] dev_rx_data,
   input  logic                dev_rx_rd,
   output logic                dev_rx_empty,
   output logic [1:0]          err_flags,
   input  logic                err_clr
);
   localparam int CW = AW + 1;

   logic [TX_WIDTH-1:0] tx_mem [DEPTH];
   logic [RX_WIDTH-1:0] rx_mem [DEPTH];

   logic                tx_arm_q, tx_arm_d, tx_clk_q, tx_clk_d;
   logic                rx_arm_q, rx_arm_d, rx_clk_q, rx_clk_d;
   logic [AW-1:0]       tx_rd_q, tx_rd_d, tx_wr_q, tx_wr_d;
   logic [AW-1:0]       rx_rd_q, rx_rd_d, rx_wr_q, rx_wr_d;
   logic [CW-1:0]       tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
   logic [TX_WIDTH-1:0] tx_data_q, tx_data_d;
   logic [RX_WIDTH-1:0] rx_data_q, rx_data_d;
   logic [1:0]          err_q, err_d;
   logic                tx_ev, tx_pop, tx_push, tx_err;
   logic                rx_ev, rx_req, rx_pop, rx_push, rx_err, rx_head_upd;

   always_comb begin
      tx_arm_d    = 1'b1;
      rx_arm_d    = 1'b1;
      tx_clk_d    = link_tx_clk;
      rx_clk_d    = link_rx_clk;
      tx_ev       = tx_arm_q & (link_tx_clk ^ tx_clk_q);
      tx_pop      = tx_ev & (tx_cnt_q != '0);
      // a same-cycle pop frees the slot a full FIFO would otherwise refuse
      tx_push     = dev_tx_wr & (dev_tx_data != '0) & ((tx_cnt_q != CW'(DEPTH)) | tx_pop);
      tx_err      = dev_tx_wr & ~tx_push;
      tx_rd_d     = tx_rd_q + AW'(tx_pop);
      tx_wr_d     = tx_wr_q + AW'(tx_push);
      tx_cnt_d    = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
      tx_data_d   = tx_ev ? (tx_pop ? tx_mem[tx_rd_q] : '0) : tx_data_q;
      rx_ev       = rx_arm_q & (link_rx_clk ^ rx_clk_q);
      rx_req      = rx_ev & link_rx_valid;
      rx_pop      = dev_rx_rd & (rx_cnt_q != '0);
      rx_push     = rx_req & ((rx_cnt_q != CW'(DEPTH)) | rx_pop);
      rx_err      = rx_req & ~rx_push;
      rx_rd_d     = rx_rd_q + AW'(rx_pop);
      rx_wr_d     = rx_wr_q + AW'(rx_push);
      rx_cnt_d    = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
      // new head may be the word being written this cycle, so bypass the array
      rx_head_upd = (rx_push & (rx_cnt_q == '0)) | (rx_pop & (rx_cnt_d != '0));
      rx_data_d   = rx_head_upd ? ((rx_push & (rx_wr_q == rx_rd_d)) ? link_rx_data : rx_mem[rx_rd_d])
                                : rx_data_q;
      err_d       = (err_clr ? 2'b00 : err_q) | {rx_err, tx_err};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_arm_q  <= 1'b0;
         rx_arm_q  <= 1'b0;
         tx_clk_q  <= 1'b0;
         rx_clk_q  <= 1'b0;
         tx_rd_q   <= '0;
         tx_wr_q   <= '0;
         tx_cnt_q  <= '0;
         rx_rd_q   <= '0;
         rx_wr_q   <= '0;
         rx_cnt_q  <= '0;
         tx_data_q <= '0;
         rx_data_q <= '0;
         err_q     <= '0;
      end else begin
         tx_arm_q  <= tx_arm_d;
         rx_arm_q  <= rx_arm_d;
         tx_clk_q  <= tx_clk_d;
         rx_clk_q  <= rx_clk_d;
         tx_rd_q   <= tx_rd_d;
         tx_wr_q   <= tx_wr_d;
         tx_cnt_q  <= tx_cnt_d;
         rx_rd_q   <= rx_rd_d;
         rx_wr_q   <= rx_wr_d;
         rx_cnt_q  <= rx_cnt_d;
         tx_data_q <= tx_data_d;
         rx_data_q <= rx_data_d;
         err_q     <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr_q] <= dev_tx_data;
      if (rx_push) rx_mem[rx_wr_q] <= link_rx_data;
   end

   assign dev_tx_full  = tx_cnt_q == CW'(DEPTH);
   assign dev_rx_empty = rx_cnt_q == '0;
   assign link_tx_data = tx_data_q;
   assign dev_rx_data  = rx_data_q;
   assign err_flags    = err_q;
endmodule

// File: tb/tb_io_link_peer.sv
// tb_io_link_peer: random stimulus against a queue model; a monitor scores link and device outputs.
module tb_io_link_peer;
   logic        clk = 0, rst = 1;
   logic [15:0] dev_tx_data = 0;
   logic        dev_tx_wr = 0, link_tx_clk = 0, link_rx_clk = 0, link_rx_valid = 0;
   logic        dev_rx_rd = 0, err_clr = 0;
   logic [12:0] link_rx_data = 0;
   logic        dev_tx_full, dev_rx_empty;
   logic [15:0] link_tx_data;
   logic [12:0] dev_rx_data;
   logic [1:0]  err_flags;

   always #5 clk = ~clk;

   io_link_peer dut (
      .clk(clk), .rst(rst), .dev_tx_data(dev_tx_data), .dev_tx_wr(dev_tx_wr),
      .dev_tx_full(dev_tx_full), .link_tx_clk(link_tx_clk), .link_tx_data(link_tx_data),
      .link_rx_clk(link_rx_clk), .link_rx_data(link_rx_data), .link_rx_valid(link_rx_valid),
      .dev_rx_data(dev_rx_data), .dev_rx_rd(dev_rx_rd), .dev_rx_empty(dev_rx_empty),
      .err_flags(err_flags), .err_clr(err_clr)
   );

   int          checks = 0, errors = 0;
   logic [15:0] tx_model[$], tx_exp[$];
   logic [12:0] rx_exp[$];
   int          rx_cnt = 0;
   logic [1:0]  exp_err = 0;
   int          rd_kind = 0;
   logic        m_arm = 0, m_prev = 0, m_tick = 0;
   logic [15:0] cur_tx = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // one clock of stimulus; the model is updated with what the link should do this cycle
   task automatic step(bit twr, logic [15:0] td, bit ttog, bit rtog, bit rv, logic [12:0] rdat,
                       bit rrd, bit clr);
      bit terr = 0, rerr = 0, rd_ok;
      @(negedge clk);
      dev_tx_wr = twr; dev_tx_data = td; link_tx_clk = link_tx_clk ^ ttog;
      link_rx_clk = link_rx_clk ^ rtog; link_rx_valid = rv; link_rx_data = rdat;
      dev_rx_rd = rrd; err_clr = clr;
      if (ttog) tx_exp.push_back(tx_model.size() > 0 ? tx_model.pop_front() : 16'h0);
      if (twr) begin
         if (td != 0 && tx_model.size() < 16) tx_model.push_back(td);
         else terr = 1;
      end
      rd_ok = rrd && rx_cnt > 0;
      rd_kind = rd_ok ? 1 : (rrd ? 2 : 0);
      if (rtog && rv) begin
         if (rx_cnt < 16 || rd_ok) begin rx_exp.push_back(rdat); rx_cnt++; end
         else rerr = 1;
      end
      if (rd_ok) rx_cnt--;
      exp_err = (clr ? 2'b00 : exp_err) | {rerr, terr};
      @(posedge clk); #1;
      chk("tx_full", dev_tx_full, tx_model.size() == 16);
      chk("rx_empty", dev_rx_empty, rx_cnt == 0);
      chk("err_flags", err_flags, exp_err);
   endtask

   task automatic idle(int n);
      repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1; dev_tx_wr = 0; dev_rx_rd = 0; err_clr = 0; link_rx_valid = 0; rd_kind = 0;
      tx_model.delete(); tx_exp.delete(); rx_exp.delete(); rx_cnt = 0; exp_err = 0;
      repeat (3) begin
         @(negedge clk);
         link_tx_clk = ~link_tx_clk; link_rx_clk = ~link_rx_clk;
      end
      chk("rst_tx_full", dev_tx_full, 0);
      chk("rst_rx_empty", dev_rx_empty, 1);
      chk("rst_link_tx", link_tx_data, 0);
      chk("rst_rx_data", dev_rx_data, 0);
      chk("rst_err", err_flags, 0);
      // first clk after release must only arm the detectors, even with valid RX data offered
      @(negedge clk);
      rst = 0; link_tx_clk = 1; link_rx_clk = 1; link_rx_valid = 1; link_rx_data = 13'h0AA;
      @(posedge clk); #1;
      chk("arm_no_rx", dev_rx_empty, 1);
      chk("arm_no_tx", link_tx_data, 0);
      idle(2);
   endtask

   always @(posedge clk) begin
      if (rst) begin
         m_arm = 0; cur_tx = 0; m_prev = link_tx_clk;
      end else begin
         m_tick = m_arm && (link_tx_clk != m_prev);
         m_arm = 1; m_prev = link_tx_clk;
         if (rd_kind == 1) begin
            chk("rx_avail", dev_rx_empty, 0);
            if (rx_exp.size() == 0) begin
               checks++; errors++;
               $display("FAIL rx_scoreboard: got a read expected none pending");
            end else chk("rx_data", dev_rx_data, rx_exp.pop_front());
         end else if (rd_kind == 2) chk("rx_rd_empty", dev_rx_empty, 1);
         #1;
         if (m_tick) begin
            if (tx_exp.size() == 0) begin
               checks++; errors++;
               $display("FAIL tx_scoreboard: got a tick expected none pending");
            end else cur_tx = tx_exp.pop_front();
         end
         chk("link_tx_data", link_tx_data, cur_tx);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      do_reset();
      step(1, 16'h0041, 0, 0, 0, 0, 0, 0);
      step(1, 16'h0042, 0, 0, 0, 0, 0, 0);
      repeat (3) begin step(0, 0, 1, 0, 0, 0, 0, 0); idle(3); end
      for (int i = 0; i < 16; i++) step(1, 16'($urandom_range(1, 16'hFFFF)), 0, 0, 0, 0, 0, 0);
      step(1, 16'h1234, 0, 0, 0, 0, 0, 0);
      chk("tx_overflow_flag", err_flags, 2'b01);
      step(1, 16'h0000, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1);
      chk("tx_err_cleared", err_flags, 2'b00);
      for (int i = 0; i < 17; i++) begin step(0, 0, 1, 0, 0, 0, 0, 0); idle(1); end
      step(0, 0, 0, 1, 1, 13'h1AB, 0, 0);
      step(0, 0, 0, 1, 1, 13'h000, 0, 0);
      step(0, 0, 0, 1, 1, 13'h005, 0, 0);
      step(0, 0, 0, 1, 0, 13'h1FF, 0, 0);
      for (int i = 0; i < 20 && rx_cnt > 0; i++) step(0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 1, 13'($urandom), 0, 0);
      step(0, 0, 0, 1, 1, 13'h0123, 1, 0);
      chk("rx_simul_no_err", err_flags, 2'b00);
      step(0, 0, 0, 1, 1, 13'h0456, 0, 0);
      chk("rx_overflow_flag", err_flags, 2'b10);
      step(0, 0, 0, 1, 1, 13'h0789, 0, 1);
      chk("clr_vs_err", err_flags, 2'b10);
      step(0, 0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 20 && rx_cnt > 0; i++) step(0, 0, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 2) != 0,
              $urandom_range(0, 15) == 0 ? 16'h0 : 16'($urandom),
              $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 3) != 0, 13'($urandom),
              $urandom_range(0, 2) == 0, $urandom_range(0, 40) == 0);
      for (int i = 0; i < 20 && (tx_model.size() > 0 || rx_cnt > 0); i++)
         step(0, 0, 1, 0, 0, 0, 1, 0);
      step(0, 0, 1, 0, 0, 0, 0, 1);
      idle(2);
      step(1, 16'h0A0A, 0, 1, 1, 13'h0B0B, 0, 0);
      step(1, 16'h0C0C, 0, 1, 1, 13'h0D0D, 0, 0);
      do_reset();
      step(0, 0, 1, 0, 0, 0, 0, 0);
      idle(2);
      chk("tx_exp_left", tx_exp.size(), 0);
      chk("rx_exp_left", rx_exp.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
